// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the ALU execution unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_DIVU = 4'b0110,
        OP_REMU = 4'b0111
    } alu_opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic [1:0] CLASS_LS = 2'b00;
    localparam logic [1:0] CLASS_BR = 2'b01;
    localparam logic [1:0] CLASS_R  = 2'b10;
    localparam logic [1:0] CLASS_I  = 2'b11;

    function automatic logic is_iterative(input alu_opcode_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {alu_op, funct7, funct3} into an internal op code.
// DIVU/REMU decode only when ALU_EXEC_DIV_EN is defined; otherwise they fall back to ADD.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output alu_opcode_e op
);

    always_comb begin
        op = OP_ADD;
        case (alu_op)
            CLASS_LS: op = OP_ADD;
            CLASS_BR: op = OP_SUB;
            CLASS_I:  op = (funct3 == 3'b001) ? OP_SUB : OP_ADD;
            CLASS_R: begin
                case ({funct7, funct3})
                    10'b0000000_000: op = OP_ADD;
                    10'b0100000_000: op = OP_SUB;
                    10'b0000001_000: op = OP_MUL;
                    10'b0000000_100: op = OP_XOR;
                    10'b0000000_110: op = OP_OR;
                    10'b0000000_111: op = OP_AND;
`ifdef ALU_EXEC_DIV_EN
                    10'b0000001_101: op = OP_DIVU;
                    10'b0000001_111: op = OP_REMU;
`endif
                    default:         op = OP_ADD;
                endcase
            end
            default:  op = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/add/sub plus bit-serial shift-add multiply.
// Restoring divide (DIVU/REMU) is built only when ALU_EXEC_DIV_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// ITER  | one multiply/divide bit per cycle, busy high
// DONE  | result held with out_valid until out_ready
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    alu_opcode_e     op_q, op_d, dec_op;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [XLEN-1:0] single_res;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ALU_EXEC_DIV_EN
    logic [XLEN:0]   rem_sh;
    logic            div_ok;
`endif

    alu_op_decode u_dec (
        .alu_op (alu_op),
        .funct3 (funct3),
        .funct7 (funct7),
        .op     (dec_op)
    );

    always_comb begin
        case (dec_op)
            OP_SUB:  single_res = op_a - op_b;
            OP_AND:  single_res = op_a & op_b;
            OP_OR:   single_res = op_a | op_b;
            OP_XOR:  single_res = op_a ^ op_b;
            default: single_res = op_a + op_b;
        endcase
    end

    // a_q: multiplicand / dividend-then-quotient; b_q: multiplier / divisor; acc_q: product / remainder
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef ALU_EXEC_DIV_EN
        rem_sh   = {acc_q, a_q[XLEN-1]};
        div_ok   = rem_sh >= {1'b0, b_q};
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = dec_op;
                    a_d   = op_a;
                    b_d   = op_b;
                    acc_d = '0;
                    cnt_d = CW'(XLEN - 1);
                    if (is_iterative(dec_op)) begin
                        state_d = ITER;
                    end else begin
                        result_d = single_res;
                        state_d  = DONE;
                    end
                end
            end
            ITER: begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
`ifdef ALU_EXEC_DIV_EN
                if (op_q == OP_DIVU || op_q == OP_REMU) begin
                    acc_d = div_ok ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], div_ok};
                    b_d   = b_q;
                end
`endif
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = acc_d;
`ifdef ALU_EXEC_DIV_EN
                    if (op_q == OP_DIVU) result_d = a_d;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ITER);
    assign result    = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32), both with and without ALU_EXEC_DIV_EN.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, bcnt, vcnt;

    typedef struct {
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        alu_op   = aop;
        funct3   = f3;
        funct7   = f7;
        op_a     = a;
        op_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge; bounded at 64 cycles.
    task automatic wait_done(output int c, output int bc);
        c  = 1;
        bc = 0;
        while (!out_valid && c < 64) begin
            if (busy) bc++;
            step();
            c++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_drain", out_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'b0; op_a = '0; op_b = '0;
        step(); step();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_result", result, 32'h0);
        reset = 1'b0;
        step();
        chk("in_ready_after_reset", in_ready, 1'b1);

        // R-type SUB 5-7 wraps
        issue(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7);
        wait_done(cyc, bcnt);
        chk("sub_latency", cyc, 1);
        chk("sub_result", result, 32'hFFFF_FFFE);
        chk("sub_in_ready_low", in_ready, 1'b0);
        drain();

        // MUL wraps modulo 2^32
        issue(2'b10, 3'b000, 7'b0000001, 32'h0001_0000, 32'h0001_0001);
        chk("mul_busy_start", busy, 1'b1);
        wait_done(cyc, bcnt);
        chk("mul_busy_cycles", bcnt, 32);
        chk("mul_latency", cyc, 33);
        chk("mul_result", result, 32'h0001_0000);
        chk("mul_busy_done", busy, 1'b0);
        drain();

        // in_valid during ITER is ignored
        issue(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd5);
        step(); step(); step();
        in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd100; op_b = 32'd1;
        step(); step(); step(); step();
        in_valid = 1'b0;
        wait_done(cyc, bcnt);
        chk("ignore_latency", cyc + 7, 33);
        chk("ignore_result", result, 32'd15);
        drain();
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) vcnt++;
            step();
        end
        chk("ignore_no_extra_result", vcnt, 0);

        // ADD held with out_ready low for 10 cycles; in_valid offered meanwhile
        issue(2'b00, 3'b000, 7'b0, 32'd3, 32'd4);
        in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd1; op_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_result", result, 32'd7);
            chk("hold_in_ready", in_ready, 1'b0);
            step();
        end
        in_valid = 1'b0;
        drain();
        issue(2'b00, 3'b000, 7'b0, 32'd10, 32'd20);
        wait_done(cyc, bcnt);
        chk("after_hold_result", result, 32'd30);
        drain();

        // Back-to-back single-cycle ops with out_ready held high
        vecs.push_back('{2'b10, 3'b100, 7'b0000000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00});
        vecs.push_back('{2'b10, 3'b110, 7'b0000000, 32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F});
        vecs.push_back('{2'b10, 3'b111, 7'b0000000, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000});
        vecs.push_back('{2'b10, 3'b000, 7'b0000000, 32'hFFFF_FFFF, 32'd2,         32'd1});
        vecs.push_back('{2'b10, 3'b001, 7'b0000000, 32'd5,         32'd6,         32'd11});
        vecs.push_back('{2'b01, 3'b000, 7'b0000000, 32'd10,        32'd3,         32'd7});
        vecs.push_back('{2'b11, 3'b001, 7'b0000000, 32'd3,         32'd10,        32'hFFFF_FFF9});
        vecs.push_back('{2'b11, 3'b000, 7'b0100000, 32'd3,         32'd10,        32'd13});
        vecs.push_back('{2'b11, 3'b010, 7'b0000000, 32'd3,         32'd10,        32'd13});
`ifndef ALU_EXEC_DIV_EN
        vecs.push_back('{2'b10, 3'b101, 7'b0000001, 32'd100,       32'd7,         32'd107});
        vecs.push_back('{2'b10, 3'b111, 7'b0000001, 32'd100,       32'd7,         32'd107});
`endif
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            issue(vecs[i].aop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            chk($sformatf("b2b_valid_%0d", i), out_valid, 1'b1);
            chk($sformatf("b2b_result_%0d", i), result, vecs[i].exp);
            step();
        end
        out_ready = 1'b0;

`ifdef ALU_EXEC_DIV_EN
        issue(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7);
        wait_done(cyc, bcnt);
        chk("divu_latency", cyc, 33);
        chk("divu_result", result, 32'd14);
        drain();
        issue(2'b10, 3'b111, 7'b0000001, 32'd100, 32'd7);
        wait_done(cyc, bcnt);
        chk("remu_result", result, 32'd2);
        drain();
        issue(2'b10, 3'b101, 7'b0000001, 32'd9, 32'd0);
        wait_done(cyc, bcnt);
        chk("divu_zero_latency", cyc, 33);
        chk("divu_zero_result", result, 32'hFFFF_FFFF);
        drain();
        issue(2'b10, 3'b111, 7'b0000001, 32'd9, 32'd0);
        wait_done(cyc, bcnt);
        chk("remu_zero_result", result, 32'd9);
        drain();
`endif

        // Reset in the middle of a MUL
        issue(2'b10, 3'b000, 7'b0000001, 32'h1234_5678, 32'h0000_00FF);
        repeat (10) step();
        chk("mid_mul_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_result", result, 32'h0);
        chk("abort_in_ready", in_ready, 1'b1);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) vcnt++;
            step();
        end
        chk("abort_no_stale", vcnt, 0);
        issue(2'b00, 3'b000, 7'b0, 32'd1, 32'd1);
        wait_done(cyc, bcnt);
        chk("post_abort_result", result, 32'd2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  input  1  operation offered; in_ready  output  1  unit can accept.
REQ-005 SHALL have ports: alu_op  input  2  class (00 load/store, 01 branch, 10 R-type, 11 I-type); funct3  input  3; funct7  input  7.
REQ-006 SHALL have ports: op_a  input  XLEN  first operand; op_b  input  XLEN  second operand or immediate.
REQ-007 SHALL have ports: out_valid  output  1  result held; out_ready  input  1  consumer accepts; result  output  XLEN  result value.
REQ-008 SHALL have port: busy  output  1  high while an iterative operation runs.

Function
REQ-009 SHALL decode: alu_op 00->ADD; 01->SUB; 11 with funct3 000->ADD, 001->SUB (custom SUBI), other->ADD.
REQ-010 SHALL decode alu_op 10 on {funct7,funct3}: 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL, 0000000_100 XOR, 0000000_110 OR, 0000000_111 AND, other ADD.
REQ-011 SHALL accept an operation on a clk edge where in_valid and in_ready are both high, capturing decoded op and operands.
REQ-012 SHALL drive in_ready high only in state IDLE.
REQ-013 SHALL use states IDLE, ITER, DONE: IDLE->DONE for ADD/SUB/AND/OR/XOR; IDLE->ITER for MUL/DIVU/REMU; ITER->DONE after XLEN iterations; DONE->IDLE when out_ready high.
REQ-014 SHALL raise out_valid exactly in DONE, with result stable until the out_valid && out_ready edge.
REQ-015 SHALL give latency 1 cycle (accept edge to out_valid) for single-cycle ops, XLEN+1 cycles for MUL/DIVU/REMU.
REQ-016 SHALL compute all arithmetic modulo 2^XLEN; MUL returns the low XLEN bits of the unsigned product via shift-add, one bit per cycle.
REQ-017 SHALL hold busy high exactly while in ITER.
REQ-018 SHALL ignore in_valid while not in IDLE; no operation is dropped or queued.
REQ-019 SHALL allow back-to-back: out_ready held high gives DONE->IDLE, new accept on the following edge (one idle bubble).

Reset
REQ-020 SHALL, on reset high at a clk edge, enter IDLE, clear out_valid, busy, result and all iteration registers to 0, regardless of state.
REQ-021 SHALL abort an in-flight ITER or held DONE result on reset without emitting out_valid.
REQ-022 SHALL drive in_ready high on the first edge after reset deasserts.

Configuration
REQ-023 SHALL honour macro ALU_EXEC_DIV_EN: defined -> {0000001_101} DIVU and {0000001_111} REMU by restoring division, one quotient bit per cycle, XLEN+1 latency.
REQ-024 SHALL with ALU_EXEC_DIV_EN defined and op_b==0 return quotient all-ones and remainder op_a, same latency.
REQ-025 SHALL without ALU_EXEC_DIV_EN decode those codes as ADD (single-cycle) and contain no divider logic.

Structure
REQ-026 SHALL place 4-bit op codes (ADD 0000, SUB 0001, MUL 0010, AND 0011, OR 0100, XOR 0101, DIVU 0110, REMU 0111) and the state enum in shared package alu_pkg.
REQ-027 SHALL implement decode (REQ-009/010/023/025) in combinational sub-module alu_op_decode; sequencing, datapath, handshake stay in alu_exec_unit.

Verification
REQ-028 SHALL cover: XLEN=32, alu_op 10, {0100000_000}, a=5, b=7 -> out_valid 1 cycle after accept, result 0xFFFFFFFE.
REQ-029 SHALL cover: MUL a=0x0001_0000, b=0x0001_0001 -> busy 32 cycles, out_valid at cycle 33, result 0x0001_0000 (wrap).
REQ-030 SHALL cover: out_ready held low 10 cycles after ADD 3+4 -> result 7 and out_valid stable, in_ready low throughout, then one accept.
REQ-031 SHALL cover: reset pulsed mid-MUL at iteration 10 -> next cycle out_valid 0, busy 0, result 0, in_ready 1; no stale result later.
REQ-032 SHALL cover (ALU_EXEC_DIV_EN): DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9; without macro DIVU 100/7 -> 107 in 1 cycle.
REQ-033 SHALL cover: in_valid pulsed during ITER with alu_op 00 -> ignored; only the original MUL result appears.
